// File: rtl/ffa_arb_pkg.sv
// Shared types, limits and helpers for the flip-flop array access arbiter.
package ffa_arb_pkg;

  // Largest supported requester count.
  localparam int unsigned FFA_ARB_MAX_REQ = 8;

  // Default widths used by the request struct below.
  localparam int unsigned FFA_ARB_DEF_DATA_W = 8;
  localparam int unsigned FFA_ARB_DEF_ADDR_W = 3;

  // Index width for n items, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One requester-side access as held stable until transfer.
  typedef struct packed {
    logic                          we;
    logic [FFA_ARB_DEF_ADDR_W-1:0] addr;
    logic [FFA_ARB_DEF_DATA_W-1:0] wdata;
  } ffa_req_t;

endpackage

// File: rtl/ffa_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module ffa_rr_pick
  import ffa_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0] pos;

  // Scan N positions from rr_ptr, modulo N; the first hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, rr_ptr} + (IW+1)'(i);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end
      if (!any && req[pos[IW-1:0]]) begin
        any               = 1'b1;
        gnt[pos[IW-1:0]]  = 1'b1;
        idx               = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/ffa_access_arbiter.sv
// Round-robin arbiter sharing one flip-flop register array among REQ_N requesters.
// One access per cycle; reads return data with requester ID one cycle after grant
// through a single-slot response register with backpressure.
// Optional: define FFA_ARB_SHADOW_VALID_EN to track written entries locally and
// complete reads of unwritten entries without touching the array.
module ffa_access_arbiter
  import ffa_arb_pkg::*;
#(
  parameter  int unsigned REQ_N  = 4,
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned ADDR_W = 3,
  localparam int unsigned ID_W   = clog2_min1(REQ_N)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [REQ_N-1:0]         req_valid,
  input  logic [REQ_N-1:0]         req_we,
  input  logic [REQ_N*ADDR_W-1:0]  req_addr,
  input  logic [REQ_N*DATA_W-1:0]  req_wdata,
  output logic [REQ_N-1:0]         req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err,
  output logic                     arr_wr,
  output logic                     arr_rd,
  output logic [ADDR_W-1:0]        arr_addr,
  output logic [DATA_W-1:0]        arr_din,
  input  logic [DATA_W-1:0]        arr_dout,
  input  logic                     arr_error
);

  logic              stall;
  logic [REQ_N-1:0]  pick_req;
  logic [REQ_N-1:0]  gnt;
  logic [ID_W-1:0]   gidx;
  logic              any;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              rd_grant, wr_grant;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;

  // A full response slot that is not being drained blocks every grant, writes included.
  assign stall    = rsp_valid && !rsp_ready;
  assign pick_req = stall ? '0 : req_valid;

  ffa_rr_pick #(
    .N  (REQ_N),
    .IW (ID_W)
  ) u_pick (
    .req    (pick_req),
    .rr_ptr (rr_ptr_q),
    .gnt    (gnt),
    .idx    (gidx),
    .any    (any)
  );

  assign req_ready = gnt;

  // Route the granted requester's fields; all zero when nothing is granted.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < REQ_N; i++) begin
      if (gnt[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign rd_grant = any && !sel_we;
  assign wr_grant = any && sel_we;
  assign arr_wr   = wr_grant;
  assign arr_addr = sel_addr;
  assign arr_din  = sel_wdata;

`ifdef FFA_ARB_SHADOW_VALID_EN
  localparam int unsigned DATA_N = 2**ADDR_W;

  logic [DATA_N-1:0] written_q;
  logic              rd_hit;

  assign rd_hit  = written_q[sel_addr];
  // Reads of unwritten entries are answered here and never reach the array.
  assign arr_rd  = rd_grant && rd_hit;
  assign rd_data = rd_hit ? arr_dout : '0;
  assign rd_err  = !rd_hit;

  // Mark entries as valid on each write transfer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      written_q <= '0;
    end else if (wr_grant) begin
      written_q[sel_addr] <= 1'b1;
    end
  end
`else
  assign arr_rd  = rd_grant;
  assign rd_data = arr_dout;
  assign rd_err  = arr_error;
`endif

  // Pointer moves just past the winner on any transfer.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any) begin
      rr_ptr_d = (gidx == ID_W'(REQ_N - 1)) ? '0 : gidx + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Response slot: load on read grant (possibly while popping), clear on a bare pop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else if (rd_grant) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gidx;
      rsp_data  <= rd_data;
      rsp_err   <= rd_err;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ffa_access_arbiter.sv
// Directed and randomised checks for ffa_access_arbiter against a behavioural array.
module tb_ffa_access_arbiter;
  import ffa_arb_pkg::*;

  localparam int unsigned REQ_N  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned DATA_N = 8;

  logic                    clk = 1'b0;
  logic                    resetn;
  logic [REQ_N-1:0]        req_valid;
  logic [REQ_N-1:0]        req_we;
  logic [REQ_N*ADDR_W-1:0] req_addr;
  logic [REQ_N*DATA_W-1:0] req_wdata;
  logic [REQ_N-1:0]        req_ready;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_err;
  logic                    arr_wr, arr_rd;
  logic [ADDR_W-1:0]       arr_addr;
  logic [DATA_W-1:0]       arr_din;
  logic [DATA_W-1:0]       arr_dout;
  logic                    arr_error;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ffa_access_arbiter #(
    .REQ_N  (REQ_N),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .arr_wr    (arr_wr),
    .arr_rd    (arr_rd),
    .arr_addr  (arr_addr),
    .arr_din   (arr_din),
    .arr_dout  (arr_dout),
    .arr_error (arr_error)
  );

  // Behavioural flip-flop array; entries become valid when first written.
  logic [DATA_W-1:0] mem [DATA_N];
  logic [DATA_N-1:0] mem_ok;

  always @(posedge clk) begin
    if (!resetn) begin
      mem_ok <= '0;
    end else if (arr_wr) begin
      mem[arr_addr]    <= arr_din;
      mem_ok[arr_addr] <= 1'b1;
    end
  end

  assign arr_dout  = (arr_rd && mem_ok[arr_addr]) ? mem[arr_addr] : '0;
  assign arr_error = arr_rd && !mem_ok[arr_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req_valid[i]                  = 1'b1;
    req_we[i]                     = we;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic apply_reset();
    resetn    = 1'b0;
    rsp_ready = 1'b1;
    clear_reqs();
    tick();
    tick();
    resetn = 1'b1;
  endtask

  function automatic logic [DATA_W-1:0] pat(input int a);
    return DATA_W'(8'h10 + 8'h11 * a);
  endfunction

  task automatic test_reset();
    resetn    = 1'b0;
    rsp_ready = 1'b1;
    clear_reqs();
    tick();
    tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== '0) begin
      failures++;
      $display("FAIL reset_rsp: got v=%b id=%0d data=%h err=%b, want all zero",
               rsp_valid, rsp_id, rsp_data, rsp_err);
    end
    checks++;
    if ({req_ready, arr_wr, arr_rd, arr_addr, arr_din} !== '0) begin
      failures++;
      $display("FAIL reset_idle: got ready=%b wr=%b rd=%b addr=%0d din=%h, want all zero",
               req_ready, arr_wr, arr_rd, arr_addr, arr_din);
    end
    resetn = 1'b1;
  endtask

  task automatic test_write_read();
    set_req(0, 1'b1, 3'd3, 8'hA5);
    #1;
    checks++;
    if ({req_ready, arr_wr, arr_rd, arr_addr, arr_din} !== {4'b0001, 1'b1, 1'b0, 3'd3, 8'hA5}) begin
      failures++;
      $display("FAIL wr_grant: got ready=%b wr=%b rd=%b addr=%0d din=%h, want 0001 1 0 3 a5",
               req_ready, arr_wr, arr_rd, arr_addr, arr_din);
    end
    tick();
    clear_reqs();
    set_req(1, 1'b0, 3'd3, 8'h00);
    #1;
    checks++;
    if ({req_ready, arr_wr, arr_rd, arr_addr} !== {4'b0010, 1'b0, 1'b1, 3'd3}) begin
      failures++;
      $display("FAIL rd_grant: got ready=%b wr=%b rd=%b addr=%0d, want 0010 0 1 3",
               req_ready, arr_wr, arr_rd, arr_addr);
    end
    tick();
    clear_reqs();
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 2'd1, 8'hA5, 1'b0}) begin
      failures++;
      $display("FAIL wr_rd_rsp: got v=%b id=%0d data=%h err=%b, want 1 1 a5 0",
               rsp_valid, rsp_id, rsp_data, rsp_err);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL wr_rd_pop: got rsp_valid=%b, want 0", rsp_valid);
    end
  endtask

  task automatic test_rr_order();
    apply_reset();
    // Requester 3 alone wins from pointer 0 and wraps it back to 0 each time.
    for (int a = 0; a < REQ_N; a++) begin
      clear_reqs();
      set_req(3, 1'b1, ADDR_W'(a), pat(a));
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin
        failures++;
        $display("FAIL rr_prefill: got ready=%b, want 1000", req_ready);
      end
      tick();
    end
    clear_reqs();
    for (int i = 0; i < REQ_N; i++) set_req(i, 1'b0, ADDR_W'(i), 8'h00);
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (req_ready !== REQ_N'(1 << (k % REQ_N))) begin
        failures++;
        $display("FAIL rr_grant: cycle %0d got ready=%b, want %b", k, req_ready,
                 REQ_N'(1 << (k % REQ_N)));
      end
      if (k > 0) begin
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err} !==
            {1'b1, ID_W'((k - 1) % REQ_N), pat((k - 1) % REQ_N), 1'b0}) begin
          failures++;
          $display("FAIL rr_rsp: cycle %0d got v=%b id=%0d data=%h err=%b, want 1 %0d %h 0",
                   k, rsp_valid, rsp_id, rsp_data, rsp_err, (k - 1) % REQ_N,
                   pat((k - 1) % REQ_N));
        end
      end
      tick();
    end
    clear_reqs();
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 2'd3, 8'h43, 1'b0}) begin
      failures++;
      $display("FAIL rr_last_rsp: got v=%b id=%0d data=%h err=%b, want 1 3 43 0",
               rsp_valid, rsp_id, rsp_data, rsp_err);
    end
    tick();
  endtask

  task automatic test_unwritten();
    logic exp_rd;
`ifdef FFA_ARB_SHADOW_VALID_EN
    exp_rd = 1'b0;
`else
    exp_rd = 1'b1;
`endif
    set_req(0, 1'b0, 3'd5, 8'h00);
    #1;
    checks++;
    if ({req_ready, arr_rd, arr_wr} !== {4'b0001, exp_rd, 1'b0}) begin
      failures++;
      $display("FAIL unwr_grant: got ready=%b rd=%b wr=%b, want 0001 %b 0",
               req_ready, arr_rd, arr_wr, exp_rd);
    end
    tick();
    clear_reqs();
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 2'd0, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL unwr_rsp: got v=%b id=%0d data=%h err=%b, want 1 0 00 1",
               rsp_valid, rsp_id, rsp_data, rsp_err);
    end
    tick();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    set_req(1, 1'b0, 3'd1, 8'h00);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL bp_first: got ready=%b, want 0010", req_ready);
    end
    tick();
    clear_reqs();
    for (int i = 0; i < REQ_N; i++) set_req(i, 1'b0, ADDR_W'(i), 8'h00);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({req_ready, arr_rd, arr_wr} !== '0) begin
        failures++;
        $display("FAIL bp_stall: cycle %0d got ready=%b rd=%b wr=%b, want 0000 0 0",
                 k, req_ready, arr_rd, arr_wr);
      end
      checks++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 2'd1, 8'h21, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold: cycle %0d got v=%b id=%0d data=%h err=%b, want 1 1 21 0",
                 k, rsp_valid, rsp_id, rsp_data, rsp_err);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL bp_resume: got ready=%b, want 0100", req_ready);
    end
    tick();
    clear_reqs();
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 2'd2, 8'h32, 1'b0}) begin
      failures++;
      $display("FAIL bp_next_rsp: got v=%b id=%0d data=%h err=%b, want 1 2 32 0",
               rsp_valid, rsp_id, rsp_data, rsp_err);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain: got rsp_valid=%b, want 0", rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    set_req(2, 1'b0, 3'd2, 8'h00);
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL rstmid_grant: got ready=%b, want 0100", req_ready);
    end
    tick();
    resetn = 1'b0;
    clear_reqs();
    tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== '0) begin
      failures++;
      $display("FAIL rstmid_rsp: got v=%b id=%0d data=%h err=%b, want all zero",
               rsp_valid, rsp_id, rsp_data, rsp_err);
    end
    resetn = 1'b1;
    for (int i = 0; i < REQ_N; i++) set_req(i, 1'b0, ADDR_W'(i), 8'h00);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL rstmid_ptr: got ready=%b, want 0001", req_ready);
    end
    tick();
    clear_reqs();
    tick();
  endtask

  task automatic test_random();
    ffa_req_t          pend [REQ_N];
    logic [REQ_N-1:0]  pv;
    logic [DATA_W-1:0] ref_mem [DATA_N];
    logic [DATA_N-1:0] ref_ok;
    int                ref_ptr;
    logic              exp_v;
    logic [ID_W-1:0]   exp_id;
    logic [DATA_W-1:0] exp_data;
    logic              exp_err;
    logic [REQ_N-1:0]  exp_gnt;
    int                g;
    int                j;

    apply_reset();
    pv      = '0;
    ref_ok  = '0;
    ref_ptr = 0;
    exp_v   = 1'b0;
    exp_id  = '0;
    exp_data = '0;
    exp_err = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      for (int i = 0; i < REQ_N; i++) begin
        if (!pv[i] && $urandom_range(0, 2) != 0) begin
          pv[i]         = 1'b1;
          pend[i].we    = 1'($urandom_range(0, 1));
          pend[i].addr  = ADDR_W'($urandom_range(0, DATA_N - 1));
          pend[i].wdata = DATA_W'($urandom);
        end
        req_valid[i]                  = pv[i];
        req_we[i]                     = pend[i].we;
        req_addr[i*ADDR_W +: ADDR_W]  = pend[i].addr;
        req_wdata[i*DATA_W +: DATA_W] = pend[i].wdata;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;

      exp_gnt = '0;
      g       = 0;
      if (!(exp_v && !rsp_ready)) begin
        for (int k = 0; k < REQ_N; k++) begin
          j = (ref_ptr + k) % REQ_N;
          if (exp_gnt == '0 && pv[j]) begin
            exp_gnt[j] = 1'b1;
            g          = j;
          end
        end
      end

      checks++;
      if (req_ready !== exp_gnt) begin
        failures++;
        $display("FAIL rnd_grant: cycle %0d got ready=%b, want %b", cyc, req_ready, exp_gnt);
      end
      checks++;
      if ((arr_wr & arr_rd) !== 1'b0 || !$onehot0(req_ready)) begin
        failures++;
        $display("FAIL rnd_invariant: cycle %0d got wr=%b rd=%b ready=%b, want exclusive",
                 cyc, arr_wr, arr_rd, req_ready);
      end
      checks++;
      if (rsp_valid !== exp_v) begin
        failures++;
        $display("FAIL rnd_rsp_valid: cycle %0d got %b, want %b", cyc, rsp_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if ({rsp_id, rsp_data, rsp_err} !== {exp_id, exp_data, exp_err}) begin
          failures++;
          $display("FAIL rnd_rsp: cycle %0d got id=%0d data=%h err=%b, want %0d %h %b",
                   cyc, rsp_id, rsp_data, rsp_err, exp_id, exp_data, exp_err);
        end
      end

      if (exp_gnt != '0 && !pend[g].we) begin
        exp_v    = 1'b1;
        exp_id   = ID_W'(g);
        exp_data = ref_ok[pend[g].addr] ? ref_mem[pend[g].addr] : '0;
        exp_err  = !ref_ok[pend[g].addr];
      end else if (exp_v && rsp_ready) begin
        exp_v = 1'b0;
      end
      if (exp_gnt != '0) begin
        if (pend[g].we) begin
          ref_mem[pend[g].addr] = pend[g].wdata;
          ref_ok[pend[g].addr]  = 1'b1;
        end
        ref_ptr = (g + 1) % REQ_N;
        pv[g]   = 1'b0;
      end
      tick();
    end
    clear_reqs();
    rsp_ready = 1'b1;
    tick();
  endtask

  initial begin
    resetn    = 1'b0;
    rsp_ready = 1'b1;
    clear_reqs();
    test_reset();
    test_write_read();
    test_rr_order();
    test_unwritten();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
